pe_feed_ctrl: RTL and testbench

Sequencer that sits directly upstream of PE_core in the matrix-vector coaccelerator. It reads one weight column and one vector element per cycle from the weight and vector SRAMs, and drives PE_core's alu_start and cycle_num in step with the SRAM read data. It waits for PE_core's accumulate pipeline to finish, then signals completion of one K-length outer-product accumulation.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_feed_ctrl_if.sv | 32 +++
 rtl/pe_rd_delay_pipe.sv | 34 +++
 rtl/pe_feed_ctrl.sv | 118 +++++++++++
 tb/tb_pe_feed_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and sizing for the PE array datapath: feed FSM states and the
// {valid, k} beat that travels alongside SRAM read data.
package pe_pkg;

  localparam int ARRAY_SIZE    = 4;
  localparam int DATA_WIDTH    = 16;
  localparam int K_ACCUM_DEPTH = 64;
  localparam int CYCLE_W       = 9;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_ISSUE,
    FEED_DRAIN,
    FEED_DONE
  } feed_state_t;

  typedef struct packed {
    logic               valid;
    logic [CYCLE_W-1:0] k;
  } feed_beat_t;

endpackage

// File: rtl/pe_feed_ctrl_if.sv
// Job request, SRAM read port and PE_core control bundle of the feed sequencer.
// The slave side is the sequencer; the master side requests jobs and consumes its outputs.
interface pe_feed_ctrl_if #(
  parameter int CYCLE_W      = pe_pkg::CYCLE_W,
  parameter int ADDR_W_WIDTH = 10,
  parameter int ADDR_V_WIDTH = 10
);
  logic                    start;
  logic [CYCLE_W-1:0]      k_len;
  logic [ADDR_W_WIDTH-1:0] w_base;
  logic [ADDR_V_WIDTH-1:0] v_base;
  logic                    sram_ren_w;
  logic [ADDR_W_WIDTH-1:0] sram_raddr_w;
  logic                    sram_ren_v;
  logic [ADDR_V_WIDTH-1:0] sram_raddr_v;
  logic                    alu_start;
  logic [CYCLE_W-1:0]      cycle_num;
  logic                    busy;
  logic                    done;

  modport master (
    output start, k_len, w_base, v_base,
    input  sram_ren_w, sram_raddr_w, sram_ren_v, sram_raddr_v,
    input  alu_start, cycle_num, busy, done
  );

  modport slave (
    input  start, k_len, w_base, v_base,
    output sram_ren_w, sram_raddr_w, sram_ren_v, sram_raddr_v,
    output alu_start, cycle_num, busy, done
  );
endinterface

// File: rtl/pe_rd_delay_pipe.sv
// Fixed-depth shift register of feed beats; aligns control with data that
// emerges DEPTH cycles later (SRAM read data, later write-back alignment).
module pe_rd_delay_pipe
  import pe_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       srst,
  input  feed_beat_t beat_i,
  output feed_beat_t beat_o,
  output logic       pending_o
);

  feed_beat_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= beat_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign beat_o = stage_q[DEPTH-1];

  // Valid beats that have not yet reached the output stage.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | stage_q[i].valid;
  end

endmodule

// File: rtl/pe_feed_ctrl.sv
// Feed sequencer for PE_core: streams K operand-pair reads from the weight and
// vector SRAMs, aligns alu_start/cycle_num with read data, and flags job completion.
module pe_feed_ctrl #(
  parameter int K_ACCUM_DEPTH = pe_pkg::K_ACCUM_DEPTH,
  parameter int CYCLE_W       = pe_pkg::CYCLE_W,
  parameter int ADDR_W_WIDTH  = 10,
  parameter int ADDR_V_WIDTH  = 10,
  parameter int SRAM_RD_LAT   = 1,
  parameter int PE_LATENCY    = 1
) (
  input logic           clk,
  input logic           srst,
  pe_feed_ctrl_if.slave bus
);
  import pe_pkg::*;

  localparam int BEAT_K_W = $bits(feed_beat_t) - 1;
  localparam int DCNT_W   = 8;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PE_LATENCY - 1);

  feed_state_t             state_q, state_d;
  logic [CYCLE_W-1:0]      k_q, k_d;
  logic [CYCLE_W-1:0]      klen_q, klen_d;
  logic [ADDR_W_WIDTH-1:0] w_base_q, w_base_d;
  logic [ADDR_V_WIDTH-1:0] v_base_q, v_base_d;
  logic [DCNT_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic                    issue;
  logic                    pipe_pending;
  feed_beat_t              beat_p0, beat_pn;

  function automatic logic [CYCLE_W-1:0] clamp_klen(input logic [CYCLE_W-1:0] len);
    if (len > CYCLE_W'(K_ACCUM_DEPTH)) return CYCLE_W'(K_ACCUM_DEPTH);
    return len;
  endfunction

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    klen_d      = klen_q;
    w_base_d    = w_base_q;
    v_base_d    = v_base_q;
    drain_cnt_d = drain_cnt_q;
    issue       = 1'b0;
    unique case (state_q)
      FEED_IDLE: begin
        if (bus.start) begin
          klen_d   = clamp_klen(bus.k_len);
          w_base_d = bus.w_base;
          v_base_d = bus.v_base;
          k_d      = '0;
          state_d  = (clamp_klen(bus.k_len) == '0) ? FEED_DONE : FEED_ISSUE;
        end
      end
      FEED_ISSUE: begin
        issue = 1'b1;
        if (k_q == klen_q - CYCLE_W'(1)) begin
          state_d     = FEED_DRAIN;
          drain_cnt_d = '0;
        end else begin
          k_d = k_q + CYCLE_W'(1);
        end
      end
      // Once the last beat reaches the pipe output, PE_core needs PE_LATENCY more cycles.
      FEED_DRAIN: begin
        if (!pipe_pending) begin
          if (drain_cnt_q == DRAIN_LAST) state_d = FEED_DONE;
          else                           drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        end
      end
      FEED_DONE: state_d = FEED_IDLE;
      default:   state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= FEED_IDLE;
      k_q         <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    klen_q   <= klen_d;
    w_base_q <= w_base_d;
    v_base_q <= v_base_d;
  end

  // ---- stage p0: SRAM read issue; beat enters the read-latency pipe
  assign beat_p0.valid = issue;
  assign beat_p0.k     = issue ? BEAT_K_W'(k_q) : '0;

  assign bus.sram_ren_w   = issue;
  assign bus.sram_ren_v   = issue;
  assign bus.sram_raddr_w = issue ? w_base_q + ADDR_W_WIDTH'(k_q) : '0;
  assign bus.sram_raddr_v = issue ? v_base_q + ADDR_V_WIDTH'(k_q) : '0;

  pe_rd_delay_pipe #(
    .DEPTH(SRAM_RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .srst     (srst),
    .beat_i   (beat_p0),
    .beat_o   (beat_pn),
    .pending_o(pipe_pending)
  );

  // ---- stage pN: beat aligned with SRAM rdata, presented to PE_core
  assign bus.alu_start = beat_pn.valid;
  assign bus.cycle_num = CYCLE_W'(beat_pn.k);
  assign bus.busy      = (state_q != FEED_IDLE);
  assign bus.done      = (state_q == FEED_DONE);

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Directed bench for pe_feed_ctrl: default-latency instance plus a
// SRAM_RD_LAT=3 / PE_LATENCY=2 instance, with an SRAM + PE_core accumulate model.
module tb_pe_feed_ctrl;

  logic clk = 1'b0;
  logic srst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_feed_ctrl_if #(.CYCLE_W(9), .ADDR_W_WIDTH(10), .ADDR_V_WIDTH(10)) bus0 ();
  pe_feed_ctrl_if #(.CYCLE_W(9), .ADDR_W_WIDTH(10), .ADDR_V_WIDTH(10)) bus1 ();

  pe_feed_ctrl #(
    .K_ACCUM_DEPTH(64), .CYCLE_W(9), .ADDR_W_WIDTH(10), .ADDR_V_WIDTH(10),
    .SRAM_RD_LAT(1), .PE_LATENCY(1)
  ) dut0 (.clk(clk), .srst(srst), .bus(bus0));

  pe_feed_ctrl #(
    .K_ACCUM_DEPTH(64), .CYCLE_W(9), .ADDR_W_WIDTH(10), .ADDR_V_WIDTH(10),
    .SRAM_RD_LAT(3), .PE_LATENCY(2)
  ) dut1 (.clk(clk), .srst(srst), .bus(bus1));

  // SRAM (1-cycle read) and PE_core accumulate model for dut0, Q8.8 operands.
  logic [15:0] wmem [1024];
  logic [15:0] vmem [1024];
  logic [15:0] w_rdata, v_rdata;
  logic [31:0] acc;
  logic        acc_clr = 1'b0;

  always @(posedge clk) begin
    if (bus0.sram_ren_w) w_rdata <= wmem[bus0.sram_raddr_w];
    if (bus0.sram_ren_v) v_rdata <= vmem[bus0.sram_raddr_v];
    if (acc_clr)             acc <= '0;
    else if (bus0.alu_start) acc <= acc + (32'(w_rdata) * 32'(v_rdata));
  end

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.sram_ren_w, bus0.sram_ren_v, bus0.alu_start, bus0.busy, bus0.done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {bus0.sram_ren_w, bus0.sram_ren_v, bus0.alu_start, bus0.busy, bus0.done});
    end
    checks++;
    if ({bus0.sram_raddr_w, bus0.sram_raddr_v, bus0.cycle_num} !== 29'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {bus0.sram_raddr_w, bus0.sram_raddr_v, bus0.cycle_num});
    end
    checks++;
    if ({bus1.sram_ren_w, bus1.alu_start, bus1.busy, bus1.done, bus1.cycle_num} !== 13'h0) begin
      errors++;
      $display("FAIL reset_dut1 got %h exp 0", {bus1.sram_ren_w, bus1.alu_start, bus1.busy, bus1.done, bus1.cycle_num});
    end
    srst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic       e_ren, e_alu;
    logic [9:0] e_aw, e_av;
    logic [8:0] e_k;
    for (int i = 0; i < 4; i++) begin
      wmem[16 + i] = 16'h0100;
      vmem[32 + i] = 16'(128 * (i + 1));
    end
    @(negedge clk);
    acc_clr = 1'b1; bus0.start = 1'b1; bus0.k_len = 9'd4; bus0.w_base = 10'h010; bus0.v_base = 10'h020;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      acc_clr = 1'b0; bus0.start = 1'b0;
      e_ren = (c >= 1 && c <= 4);
      e_aw  = 10'(32'h010 + c - 1);
      e_av  = 10'(32'h020 + c - 1);
      e_alu = (c >= 2 && c <= 5);
      e_k   = e_alu ? 9'(c - 2) : 9'd0;
      checks++;
      if (bus0.sram_ren_w !== e_ren || bus0.sram_ren_v !== e_ren) begin
        errors++;
        $display("FAIL basic_ren c=%0d got %b%b exp %b", c, bus0.sram_ren_w, bus0.sram_ren_v, e_ren);
      end
      if (e_ren) begin
        checks++;
        if (bus0.sram_raddr_w !== e_aw || bus0.sram_raddr_v !== e_av) begin
          errors++;
          $display("FAIL basic_addr c=%0d got %h/%h exp %h/%h", c, bus0.sram_raddr_w, bus0.sram_raddr_v, e_aw, e_av);
        end
      end
      checks++;
      if (bus0.alu_start !== e_alu || bus0.cycle_num !== e_k) begin
        errors++;
        $display("FAIL basic_alu c=%0d got %b/%0d exp %b/%0d", c, bus0.alu_start, bus0.cycle_num, e_alu, e_k);
      end
      checks++;
      if (bus0.done !== (c == 6) || bus0.busy !== (c <= 6)) begin
        errors++;
        $display("FAIL basic_done_busy c=%0d got %b%b exp %b%b", c, bus0.done, bus0.busy, (c == 6), (c <= 6));
      end
      if (c == 6) begin
        checks++;
        if (acc !== 32'h0005_0000) begin
          errors++;
          $display("FAIL basic_accum got %h exp 00050000", acc);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int         ren_cnt = 0;
    int         beats = 0;
    logic [8:0] last_k = '0;
    @(negedge clk);
    bus0.start = 1'b1; bus0.k_len = 9'd64; bus0.w_base = 10'h3F0; bus0.v_base = 10'h005;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (bus0.sram_ren_w) ren_cnt++;
      checks++;
      if (bus0.sram_ren_w !== (c <= 64)) begin
        errors++;
        $display("FAIL wrap_ren c=%0d got %b exp %b", c, bus0.sram_ren_w, (c <= 64));
      end
      if (c <= 64) begin
        checks++;
        if (bus0.sram_raddr_w !== 10'(32'h3F0 + c - 1) || bus0.sram_raddr_v !== 10'(32'h005 + c - 1)) begin
          errors++;
          $display("FAIL wrap_addr c=%0d got %h/%h exp %h/%h", c, bus0.sram_raddr_w, bus0.sram_raddr_v,
                   10'(32'h3F0 + c - 1), 10'(32'h005 + c - 1));
        end
      end
      if (bus0.alu_start) begin
        beats++;
        last_k = bus0.cycle_num;
        checks++;
        if (bus0.cycle_num !== 9'(c - 2)) begin
          errors++;
          $display("FAIL wrap_k c=%0d got %0d exp %0d", c, bus0.cycle_num, c - 2);
        end
      end
      checks++;
      if (bus0.done !== (c == 66)) begin
        errors++;
        $display("FAIL wrap_done c=%0d got %b exp %b", c, bus0.done, (c == 66));
      end
    end
    checks++;
    if (ren_cnt != 64 || beats != 64 || last_k !== 9'd63) begin
      errors++;
      $display("FAIL wrap_counts got ren=%0d beats=%0d last=%0d exp 64/64/63", ren_cnt, beats, last_k);
    end
  endtask

  task automatic test_zero_and_clamp();
    int         beats = 0;
    logic [8:0] last_k = '0;
    @(negedge clk);
    bus0.start = 1'b1; bus0.k_len = 9'd0; bus0.w_base = 10'h100; bus0.v_base = 10'h200;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      checks++;
      if ({bus0.sram_ren_w, bus0.sram_ren_v, bus0.alu_start} !== 3'b0 ||
          bus0.done !== (c == 1) || bus0.busy !== (c == 1)) begin
        errors++;
        $display("FAIL zero_len c=%0d got ren=%b alu=%b done=%b busy=%b exp done/busy=%b", c,
                 bus0.sram_ren_w, bus0.alu_start, bus0.done, bus0.busy, (c == 1));
      end
    end
    bus0.start = 1'b1; bus0.k_len = 9'd100; bus0.w_base = 10'h000; bus0.v_base = 10'h000;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (bus0.alu_start) begin
        beats++;
        last_k = bus0.cycle_num;
      end
      checks++;
      if (bus0.done !== (c == 66)) begin
        errors++;
        $display("FAIL clamp_done c=%0d got %b exp %b", c, bus0.done, (c == 66));
      end
    end
    checks++;
    if (beats != 64 || last_k !== 9'd63) begin
      errors++;
      $display("FAIL clamp_beats got %0d last=%0d exp 64 last=63", beats, last_k);
    end
  endtask

  task automatic test_start_ignored();
    logic       e_ren, e_alu, e_done, e_busy;
    logic [9:0] e_aw, e_av;
    logic [8:0] e_k;
    @(negedge clk);
    bus0.start = 1'b1; bus0.k_len = 9'd4; bus0.w_base = 10'h100; bus0.v_base = 10'h200;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      e_ren  = (c <= 4) || (c >= 8 && c <= 9);
      e_aw   = (c <= 4) ? 10'(32'h100 + c - 1) : 10'(32'h300 + c - 8);
      e_av   = (c <= 4) ? 10'(32'h200 + c - 1) : 10'(32'h180 + c - 8);
      e_alu  = (c >= 2 && c <= 5) || (c >= 9 && c <= 10);
      e_k    = (c >= 2 && c <= 5) ? 9'(c - 2) : (c >= 9 && c <= 10) ? 9'(c - 9) : 9'd0;
      e_done = (c == 6) || (c == 11);
      e_busy = (c <= 6) || (c >= 8 && c <= 11);
      checks++;
      if (bus0.sram_ren_w !== e_ren || (e_ren && (bus0.sram_raddr_w !== e_aw || bus0.sram_raddr_v !== e_av))) begin
        errors++;
        $display("FAIL ign_ren c=%0d got %b %h/%h exp %b %h/%h", c, bus0.sram_ren_w,
                 bus0.sram_raddr_w, bus0.sram_raddr_v, e_ren, e_aw, e_av);
      end
      checks++;
      if (bus0.alu_start !== e_alu || bus0.cycle_num !== e_k) begin
        errors++;
        $display("FAIL ign_alu c=%0d got %b/%0d exp %b/%0d", c, bus0.alu_start, bus0.cycle_num, e_alu, e_k);
      end
      checks++;
      if (bus0.done !== e_done || bus0.busy !== e_busy) begin
        errors++;
        $display("FAIL ign_done_busy c=%0d got %b%b exp %b%b", c, bus0.done, bus0.busy, e_done, e_busy);
      end
      if (c == 2 || c == 6) begin
        bus0.start = 1'b1; bus0.k_len = 9'd9; bus0.w_base = 10'h077; bus0.v_base = 10'h066;
      end else if (c == 7) begin
        bus0.start = 1'b1; bus0.k_len = 9'd2; bus0.w_base = 10'h300; bus0.v_base = 10'h180;
      end
    end
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk);
    bus0.start = 1'b1; bus0.k_len = 9'd8; bus0.w_base = 10'h040; bus0.v_base = 10'h080;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (c <= 3) begin
        checks++;
        if (bus0.sram_ren_w !== 1'b1 || bus0.sram_raddr_w !== 10'(32'h040 + c - 1)) begin
          errors++;
          $display("FAIL rstmid_pre c=%0d got %b/%h exp 1/%h", c, bus0.sram_ren_w, bus0.sram_raddr_w, 10'(32'h040 + c - 1));
        end
        if (c == 3) srst = 1'b1;
      end else begin
        srst = 1'b0;
        checks++;
        if ({bus0.sram_ren_w, bus0.sram_ren_v, bus0.alu_start, bus0.busy, bus0.done} !== 5'b0 ||
            {bus0.sram_raddr_w, bus0.sram_raddr_v, bus0.cycle_num} !== 29'h0) begin
          errors++;
          $display("FAIL rstmid_post c=%0d got ren=%b alu=%b busy=%b done=%b k=%0d exp all 0", c,
                   bus0.sram_ren_w, bus0.alu_start, bus0.busy, bus0.done, bus0.cycle_num);
        end
      end
    end
    bus0.start = 1'b1; bus0.k_len = 9'd3; bus0.w_base = 10'h050; bus0.v_base = 10'h060;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      checks++;
      if (bus0.sram_ren_w !== (c <= 3) || ((c <= 3) && bus0.sram_raddr_v !== 10'(32'h060 + c - 1))) begin
        errors++;
        $display("FAIL rstmid_new_ren c=%0d got %b/%h exp %b/%h", c, bus0.sram_ren_w, bus0.sram_raddr_v,
                 (c <= 3), 10'(32'h060 + c - 1));
      end
      checks++;
      if (bus0.alu_start !== (c >= 2 && c <= 4) || bus0.cycle_num !== ((c >= 2 && c <= 4) ? 9'(c - 2) : 9'd0) ||
          bus0.done !== (c == 5)) begin
        errors++;
        $display("FAIL rstmid_new_alu c=%0d got alu=%b k=%0d done=%b", c, bus0.alu_start, bus0.cycle_num, bus0.done);
      end
    end
  endtask

  task automatic test_lat3();
    logic       e_alu;
    logic [8:0] e_k;
    @(negedge clk);
    bus1.start = 1'b1; bus1.k_len = 9'd5; bus1.w_base = 10'h001; bus1.v_base = 10'h002;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      e_alu = (c >= 4 && c <= 8);
      e_k   = e_alu ? 9'(c - 4) : 9'd0;
      checks++;
      if (bus1.sram_ren_w !== (c <= 5) || ((c <= 5) && bus1.sram_raddr_w !== 10'(32'h001 + c - 1))) begin
        errors++;
        $display("FAIL lat3_ren c=%0d got %b/%h exp %b", c, bus1.sram_ren_w, bus1.sram_raddr_w, (c <= 5));
      end
      checks++;
      if (bus1.alu_start !== e_alu || bus1.cycle_num !== e_k) begin
        errors++;
        $display("FAIL lat3_alu c=%0d got %b/%0d exp %b/%0d", c, bus1.alu_start, bus1.cycle_num, e_alu, e_k);
      end
      checks++;
      if (bus1.done !== (c == 10) || bus1.busy !== (c <= 10)) begin
        errors++;
        $display("FAIL lat3_done_busy c=%0d got %b%b exp %b%b", c, bus1.done, bus1.busy, (c == 10), (c <= 10));
      end
    end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.k_len = '0; bus0.w_base = '0; bus0.v_base = '0;
    bus1.start = 1'b0; bus1.k_len = '0; bus1.w_base = '0; bus1.v_base = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_and_clamp();
    test_start_ignored();
    test_reset_mid_job();
    test_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
